// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch pulse controller.
package sr_ctrl_pkg;

  localparam int CNT_W       = 4;
  localparam int PULSE_W_DEF = 2;
  localparam int GAP_W_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } sr_state_e;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable 4-bit down-counter with a zero flag; saturates at zero instead of wrapping.
module sr_pulse_timer
  import sr_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_ctrl.sv
// Arbitrates set/clear requests into fixed-width s/r drive pulses followed by a recovery gap.
// Handshake: a req is a level held until its ack; ack is a one-cycle strobe in the last pulse cycle.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       set_ack,
  output logic       clr_ack,
  output logic       s,
  output logic       r,
  output logic       en,
  output logic       busy,
  output logic       q_exp,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  sr_state_e        state;
  sr_state_e        state_nxt;
  logic             pri;
  logic             pri_nxt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             dec;
  logic             zero;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  // State register; q_exp and pri commit alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pri   <= 1'b0;
      q_exp <= 1'b0;
    end else begin
      state <= state_nxt;
      pri   <= pri_nxt;
      if ((state == SET_P) && zero) begin
        q_exp <= 1'b1;
      end else if ((state == CLR_P) && zero) begin
        q_exp <= 1'b0;
      end
    end
  end

  // pri flips only when both requests competed for the same grant.
  always_comb begin
    state_nxt = state;
    pri_nxt   = pri;
    load      = 1'b0;
    load_val  = PULSE_LD;
    dec       = 1'b0;
    case (state)
      IDLE: begin
        if (set_req && clr_req) begin
          state_nxt = pri ? CLR_P : SET_P;
          pri_nxt   = ~pri;
          load      = 1'b1;
        end else if (set_req) begin
          state_nxt = SET_P;
          load      = 1'b1;
        end else if (clr_req) begin
          state_nxt = CLR_P;
          load      = 1'b1;
        end
      end
      SET_P, CLR_P: begin
        if (zero) begin
          state_nxt = GAP;
          load      = 1'b1;
          load_val  = GAP_LD;
        end else begin
          dec = 1'b1;
        end
      end
      GAP: begin
        if (zero) begin
          state_nxt = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // s and r decode from disjoint states, so they can never overlap.
  always_comb begin
    s         = (state == SET_P);
    r         = (state == CLR_P);
    en        = (state == SET_P) || (state == CLR_P);
    set_ack   = (state == SET_P) && zero;
    clr_ack   = (state == CLR_P) && zero;
    busy      = (state != IDLE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench: directed scenarios plus random requests against a timeline reference model.
module tb_sr_latch_ctrl;

  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic set_ack, clr_ack, s, r, en, busy, q_exp;
  logic [1:0] dbg_state;

  logic set2 = 1'b0;
  logic clr2 = 1'b0;
  logic set_ack2, clr_ack2, s2, r2, en2, busy2, q_exp2;
  logic [1:0] dbg_state2;

  int checks = 0;
  int errors = 0;

  // Reference model: one transaction = P drive cycles then G gap cycles.
  bit m_active;
  bit m_set;
  int m_t;
  bit m_q;
  bit m_pri;

  always #5 clk = ~clk;

  sr_latch_ctrl dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .set_ack(set_ack), .clr_ack(clr_ack), .s(s), .r(r), .en(en),
    .busy(busy), .q_exp(q_exp), .dbg_state(dbg_state)
  );

  sr_latch_ctrl #(.PULSE_W(1), .GAP_W(3)) dut2 (
    .clk(clk), .rst(rst), .set_req(set2), .clr_req(clr2),
    .set_ack(set_ack2), .clr_ack(clr_ack2), .s(s2), .r(r2), .en(en2),
    .busy(busy2), .q_exp(q_exp2), .dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_set    = 0;
    m_t      = 0;
    m_q      = 0;
    m_pri    = 0;
  endtask

  task automatic model_step();
    if (m_active) begin
      if (m_t == P - 1) m_q = m_set;
      m_t++;
      if (m_t == P + G) m_active = 0;
    end else if (set_req || clr_req) begin
      m_active = 1;
      m_t      = 0;
      if (set_req && clr_req) begin
        m_set = !m_pri;
        m_pri = !m_pri;
      end else begin
        m_set = set_req;
      end
    end
  endtask

  task automatic check_model();
    bit drive;
    drive = m_active && (m_t < P);
    check("s", s, drive && m_set);
    check("r", r, drive && !m_set);
    check("en", en, drive);
    check("set_ack", set_ack, m_active && m_set && (m_t == P - 1));
    check("clr_ack", clr_ack, m_active && !m_set && (m_t == P - 1));
    check("busy", busy, m_active);
    check("q_exp", q_exp, m_q);
    check("s_and_r", s & r, 0);
    check("en_is_s_or_r", en, s | r);
    check("set_ack_wo_req", set_ack & ~set_req, 0);
    check("clr_ack_wo_req", clr_ack & ~clr_req, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("rst_s", s, 0);
    check("rst_busy", busy, 0);
    check("rst_q", q_exp, 0);
    check("rst_busy2", busy2, 0);
    repeat (3) tick();
    check("idle_busy", busy, 0);

    // Single set with default widths.
    set_req = 1'b1;
    tick();
    check("set_c1_s", s, 1);
    check("set_c1_ack", set_ack, 0);
    tick();
    check("set_c2_s", s, 1);
    check("set_c2_ack", set_ack, 1);
    set_req = 1'b0;
    tick();
    check("set_c3_gap", {busy, s, r}, 3'b100);
    check("set_c3_q", q_exp, 1);
    tick();
    check("set_c4_idle", busy, 0);

    // Contention from reset: set first, then clear, then clear first next time.
    do_reset();
    set_req = 1'b1;
    clr_req = 1'b1;
    tick();
    check("cont1_s", {s, r}, 2'b10);
    tick();
    check("cont1_sack", set_ack, 1);
    set_req = 1'b0;
    tick();
    check("cont1_gap", {busy, s, r}, 3'b100);
    tick();
    tick();
    check("cont1_r", {s, r}, 2'b01);
    tick();
    check("cont1_cack", clr_ack, 1);
    clr_req = 1'b0;
    tick();
    tick();
    set_req = 1'b1;
    clr_req = 1'b1;
    tick();
    check("cont2_r_first", {s, r}, 2'b01);
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    check("cont2_then_s", s, 1);
    tick();
    set_req = 1'b0;
    repeat (2) tick();

    // Reset in the second SET_P cycle.
    do_reset();
    set_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_s", s, 0);
    check("mid_rst_ack", set_ack, 0);
    check("mid_rst_q", q_exp, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rerun_s", s, 1);
    tick();
    set_req = 1'b0;
    repeat (2) tick();

    // Second instance: PULSE_W=1, GAP_W=3; a clear arriving in GAP is ignored.
    do_reset();
    set2 = 1'b1;
    tick();
    check("p1_set_s", s2, 1);
    check("p1_set_ack", set_ack2, 1);
    set2 = 1'b0;
    clr2 = 1'b1;
    tick();
    check("p1_gap1", {busy2, s2, r2}, 3'b100);
    check("p1_q_set", q_exp2, 1);
    tick();
    check("p1_gap2", {busy2, r2}, 2'b10);
    tick();
    check("p1_gap3", {busy2, r2}, 2'b10);
    tick();
    check("p1_idle", busy2, 0);
    tick();
    check("p1_clr_r", {r2, en2, clr_ack2}, 3'b111);
    clr2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p1_clr_gap", {busy2, r2}, 2'b10);
    end
    check("p1_q_clr", q_exp2, 0);
    tick();
    check("p1_clr_idle", busy2, 0);

    // Random requests with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check("rnd_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
      end else begin
        if (set_ack) set_req = ($urandom_range(0, 3) == 0);
        else if (!set_req) set_req = ($urandom_range(0, 4) == 0);
        if (clr_ack) clr_req = ($urandom_range(0, 3) == 0);
        else if (!clr_req) clr_req = ($urandom_range(0, 4) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
- REQ-001: Parameter PULSE_W, default 2, SHALL set the number of cycles an s/r drive pulse is held (legal range 1..15).
- REQ-002: Parameter GAP_W, default 1, SHALL set the number of idle recovery cycles after each pulse (legal range 1..15).
- REQ-003: Port clk, input, 1, SHALL be the single clock; all state changes on the rising edge.
- REQ-004: Port rst, input, 1, SHALL be the reset: asynchronous, active-high.
- REQ-005: Port set_req, input, 1, SHALL request a set pulse; level, held until set_ack.
- REQ-006: Port clr_req, input, 1, SHALL request a reset pulse; level, held until clr_ack.
- REQ-007: Port set_ack, output, 1, SHALL be a one-cycle grant-complete strobe for set_req.
- REQ-008: Port clr_ack, output, 1, SHALL be a one-cycle grant-complete strobe for clr_req.
- REQ-009: Port s, output, 1, SHALL be the latch set drive.
- REQ-010: Port r, output, 1, SHALL be the latch reset drive.
- REQ-011: Port en, output, 1, SHALL be the latch gate/enable; high only while s or r is high.
- REQ-012: Port busy, output, 1, SHALL be high in every non-IDLE state.
- REQ-013: Port q_exp, output, 1, SHALL hold the expected latch state (1 after a completed set, 0 after a completed clear).

Function
- REQ-014: The FSM SHALL have exactly four states: IDLE, SET_P, CLR_P, GAP; all outputs SHALL be registered and decoded from the state.
- REQ-015: In IDLE with only set_req high, the next state SHALL be SET_P; with only clr_req high, it SHALL be CLR_P; with neither high, it SHALL remain IDLE.
- REQ-016: In IDLE with both requests high, the grant SHALL follow a priority bit pri (0 = set first); pri SHALL toggle only after a contended grant.
- REQ-017: On entering SET_P or CLR_P, the counter SHALL load PULSE_W-1; the state SHALL persist until the counter reaches 0, decrementing by 1 each cycle.
- REQ-018: SET_P SHALL drive s=1, en=1, r=0; CLR_P SHALL drive r=1, en=1, s=0.
- REQ-019: The matching ack SHALL be high only in the last pulse cycle (counter==0); q_exp SHALL update on the following edge.
- REQ-020: After the last pulse cycle, the FSM SHALL enter GAP with the counter at GAP_W-1, drive s=r=en=0, and return to IDLE when the counter reaches 0.
- REQ-021: Latency SHALL be as follows: a request sampled in IDLE at edge k makes the pulse visible from cycle k+1; a request serviced alone keeps busy high for PULSE_W+GAP_W cycles.
- REQ-022: A request still high on return to IDLE SHALL be treated as a new request, including a repeated request for the current q_exp value, which SHALL still pulse.
- REQ-023: Requests arriving outside IDLE SHALL be ignored until IDLE; there SHALL be no queuing.
- REQ-024: s and r SHALL never be high in the same cycle, including across reset and state transitions.
- REQ-025: The counter SHALL be 4 bits wide and SHALL never wrap.

Reset
- REQ-026: rst high SHALL asynchronously force IDLE, s=r=en=0, set_ack=clr_ack=0, busy=0, q_exp=0, pri=0, counter=0.
- REQ-027: A reset mid-pulse SHALL drop the drive immediately and issue no ack; the interrupted request SHALL be re-arbitrated after release.

Structure
- REQ-028: Package sr_ctrl_pkg SHALL hold the state enum typedef, the counter width constant, and the PULSE_W/GAP_W defaults.
- REQ-029: The loadable down-counter with a zero flag SHALL be the sub-module sr_pulse_timer; the FSM and arbitration SHALL stay in sr_latch_ctrl.

Verification
- REQ-030: After reset, every output SHALL read 0 and the block SHALL stay IDLE with no requests.
- REQ-031: With defaults (2,1), set_req rising before edge 1 SHALL give s=en=1 in cycles 1-2, set_ack in cycle 2, GAP in cycle 3, q_exp=1 from cycle 3, and IDLE in cycle 4.
- REQ-032: With both requests high from reset, the sequence SHALL be SET_P, GAP, CLR_P, GAP; on the next contention, clear SHALL be granted first.
- REQ-033: rst asserted in the second SET_P cycle SHALL drop s immediately with no set_ack and q_exp=0; after release, SET_P SHALL re-run.
- REQ-034: With PULSE_W=1 and GAP_W=3, a clr_req SHALL give a one-cycle r with clr_ack in the same cycle, then three busy GAP cycles.
- REQ-035: Under random request stimulus, an assertion SHALL confirm that s&r is never 1, ack appears only with a held req, and en equals s|r.
